// File: rtl/nq_pkg.sv
// NanoQuarter shared definitions: opcodes, funct codes, FSM states, decode record.
// Latency: n/a (constants and a pure combinational decode function).
// Backpressure: n/a.
package nq_pkg;

    localparam int INSTR_W = 16;
    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;
    localparam int OP_W    = 2;
    localparam int FUNCT_W = 3;
    localparam int SHAMT_W = 2;
    localparam int JT_W    = 8;
    localparam int IDATA_W = 8;
    localparam int MADDR_W = 6;
    localparam int BOFF_W  = 5;

    localparam logic [OP_W-1:0] OP_R   = 2'b00;
    localparam logic [OP_W-1:0] OP_I   = 2'b01;
    localparam logic [OP_W-1:0] OP_MEM = 2'b10;
    localparam logic [OP_W-1:0] OP_CTL = 2'b11;

    localparam logic [FUNCT_W-1:0] CTL_JMP = 3'b000;
    localparam logic [FUNCT_W-1:0] CTL_JR  = 3'b001;
    localparam logic [FUNCT_W-1:0] CTL_BNE = 3'b010;
    localparam logic [FUNCT_W-1:0] MEM_LD  = 3'b000;
    localparam logic [FUNCT_W-1:0] MEM_ST  = 3'b001;
    localparam logic [FUNCT_W-1:0] ALU_ADD = 3'b000;
    localparam logic [FUNCT_W-1:0] ALU_SUB = 3'b001;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    // Unused read ports are pointed at r0 so they read 0 and never match a hazard.
    typedef struct packed {
        logic [RADDR_W-1:0] ra1;
        logic [RADDR_W-1:0] ra2;
        logic [RADDR_W-1:0] dst;
        logic [JT_W-1:0]    jtarget;
        logic [IDATA_W-1:0] idata;
        logic [MADDR_W-1:0] memaddr;
        logic [BOFF_W-1:0]  boffset;
        logic [FUNCT_W-1:0] funct;
        logic [FUNCT_W-1:0] alufunct;
        logic [OP_W-1:0]    op;
        logic [SHAMT_W-1:0] shamt;
        logic               jr;
        logic               regwrite;
        logic               jmp;
        logic               bne;
        logic               memread;
        logic               memwrite;
        logic               bubble;
    } dec_t;

    function automatic dec_t nq_decode(input logic [INSTR_W-1:0] instr);
        dec_t d;
        d    = '0;
        d.op = instr[15:14];
        case (d.op)
            OP_R: begin
                d.ra1      = instr[13:11];
                d.ra2      = instr[10:8];
                d.dst      = instr[7:5];
                d.shamt    = instr[4:3];
                d.funct    = instr[2:0];
                d.alufunct = instr[2:0];
                d.regwrite = 1'b1;
            end
            OP_I: begin
                d.dst      = instr[13:11];
                d.funct    = instr[10:8];
                d.idata    = instr[7:0];
                d.alufunct = instr[10:8];
                d.regwrite = 1'b1;
            end
            OP_MEM: begin
                d.funct    = instr[10:8];
                d.memaddr  = instr[5:0];
                d.alufunct = ALU_ADD;
                if (instr[10:8] == MEM_LD) begin
                    d.dst      = instr[13:11];
                    d.memread  = 1'b1;
                    d.regwrite = 1'b1;
                end else if (instr[10:8] == MEM_ST) begin
                    // Store data travels on the second read port.
                    d.ra2      = instr[13:11];
                    d.memwrite = 1'b1;
                end
            end
            default: begin
                d.funct = instr[13:11];
                case (instr[13:11])
                    CTL_JMP: begin
                        d.jtarget = instr[7:0];
                        d.jmp     = 1'b1;
                    end
                    CTL_JR: begin
                        d.ra1 = instr[10:8];
                        d.jr  = 1'b1;
                    end
                    CTL_BNE: begin
                        d.ra1      = instr[10:8];
                        d.ra2      = instr[7:5];
                        d.boffset  = instr[4:0];
                        d.alufunct = ALU_SUB;
                        d.bne      = 1'b1;
                    end
                    default: d.bubble = 1'b1;
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/nq_regfile.sv
// 8x16 register file: 2 combinational read ports, 1 write port, r0 reads 0.
// Latency: reads combinational; write lands at the clock edge, bypassed to reads in the same cycle.
// Backpressure: none; a write is taken every cycle wen is high.
// Ports: clk, rst (sync, active-high, clears all entries); raddr1/raddr2 -> rdata1/rdata2;
//        wen/waddr/wdata write port (writes to r0 dropped).
module nq_regfile
    import nq_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RADDR_W-1:0] raddr1,
    input  logic [RADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]  rdata1,
    output logic [DATA_W-1:0]  rdata2,
    input  logic               wen,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (wen && (waddr == raddr1)) rdata1 = wdata;
        if (wen && (waddr == raddr2)) rdata2 = wdata;
        // r0 wins over the bypass so a stray write to r0 can never leak through.
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/fetch_decode.sv
// NanoQuarter fetch + decode: fetches over req/ack, decodes, registers the Stage 1 input bundle.
// Latency: fetch cycle then issue cycle; bundle appears one edge after issue (max 1 instr / 2 cycles).
// Backpressure: holds imem_addr until ack; load-use hazards insert bubbles; redirect_vld overrides all.
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata fetch port;
//        redirect_vld/redirect_pc; ex_memread/ex_rd hazard inputs; wb_en/wb_addr/wb_data writeback;
//        registered decode bundle (reg1data..memwrite, PC). Optional macro NQ_JMP_EARLY_EN resolves
//        jmp locally in issue instead of waiting for a downstream redirect.
module fetch_decode
    import nq_pkg::*;
#(
    parameter int              PC_W   = 32,
    parameter logic [PC_W-1:0] RST_PC = '0,
    parameter int              NREGS  = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_vld,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               ex_memread,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               wb_en,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic [DATA_W-1:0]  reg1data,
    output logic [DATA_W-1:0]  reg2data,
    output logic [JT_W-1:0]    jtarget,
    output logic [IDATA_W-1:0] idata,
    output logic [MADDR_W-1:0] memaddr,
    output logic [BOFF_W-1:0]  boffset,
    output logic [FUNCT_W-1:0] funct,
    output logic [FUNCT_W-1:0] ALUfunct,
    output logic [OP_W-1:0]    op,
    output logic [SHAMT_W-1:0] shamt,
    output logic [RADDR_W-1:0] dst_reg,
    output logic               jr,
    output logic               regwrite,
    output logic               jmp,
    output logic               stall_flg,
    output logic               bne,
    output logic               memread,
    output logic               memwrite,
    output logic [PC_W-1:0]    PC
);

    logic [1:0]         state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    ipc;
    logic [INSTR_W-1:0] instr;
    logic               drop_q;
    dec_t               dec;
    logic               hazard;
    logic               issue_ok;
    logic [DATA_W-1:0]  rdata1;
    logic [DATA_W-1:0]  rdata2;

    // drop_q keeps the request low for one cycle after a redirect so memory sees the abandon.
    assign imem_req  = (state == ST_FETCH) && !drop_q;
    assign imem_addr = pc;
    assign dec       = nq_decode(instr);
    assign hazard    = ex_memread && (ex_rd != '0) && ((ex_rd == dec.ra1) || (ex_rd == dec.ra2));

    always_comb begin
        issue_ok = !dec.bubble;
`ifdef NQ_JMP_EARLY_EN
        if (dec.jmp) issue_ok = 1'b0;
`endif
    end

    nq_regfile #(.NREGS(NREGS)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (dec.ra1),
        .raddr2 (dec.ra2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .wen    (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= RST_PC;
            ipc       <= '0;
            instr     <= '0;
            drop_q    <= 1'b0;
            reg1data  <= '0;
            reg2data  <= '0;
            jtarget   <= '0;
            idata     <= '0;
            memaddr   <= '0;
            boffset   <= '0;
            funct     <= '0;
            ALUfunct  <= '0;
            op        <= '0;
            shamt     <= '0;
            dst_reg   <= '0;
            jr        <= 1'b0;
            regwrite  <= 1'b0;
            jmp       <= 1'b0;
            stall_flg <= 1'b1;
            bne       <= 1'b0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            PC        <= '0;
        end else begin
            drop_q    <= redirect_vld;
            // Bubble by default: control flags cleared, data fields keep their last values.
            stall_flg <= 1'b1;
            regwrite  <= 1'b0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            jmp       <= 1'b0;
            jr        <= 1'b0;
            bne       <= 1'b0;
            if (redirect_vld) begin
                pc    <= redirect_pc;
                state <= ST_FETCH;
            end else begin
                case (state)
                    ST_FETCH: begin
                        if (imem_req && imem_ack) begin
                            instr <= imem_rdata;
                            ipc   <= pc;
                            pc    <= pc + {{(PC_W-1){1'b0}}, 1'b1};
                            state <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (hazard) begin
                            state <= ST_STALL;
                        end else begin
                            state <= ST_FETCH;
`ifdef NQ_JMP_EARLY_EN
                            if (dec.jmp) pc <= PC_W'(dec.jtarget);
`endif
                            if (issue_ok) begin
                                reg1data  <= rdata1;
                                reg2data  <= rdata2;
                                jtarget   <= dec.jtarget;
                                idata     <= dec.idata;
                                memaddr   <= dec.memaddr;
                                boffset   <= dec.boffset;
                                funct     <= dec.funct;
                                ALUfunct  <= dec.alufunct;
                                op        <= dec.op;
                                shamt     <= dec.shamt;
                                dst_reg   <= dec.dst;
                                jr        <= dec.jr;
                                regwrite  <= dec.regwrite;
                                jmp       <= dec.jmp;
                                bne       <= dec.bne;
                                memread   <= dec.memread;
                                memwrite  <= dec.memwrite;
                                stall_flg <= 1'b0;
                                PC        <= ipc;
                            end
                        end
                    end
                    ST_STALL: state <= ST_ISSUE;
                    default:  state <= ST_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
module tb_fetch_decode;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        ex_memread;
    logic [2:0]  ex_rd;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] reg1data, reg2data;
    logic [7:0]  jtarget, idata;
    logic [5:0]  memaddr;
    logic [4:0]  boffset;
    logic [2:0]  funct, ALUfunct, dst_reg;
    logic [1:0]  op, shamt;
    logic        jr, regwrite, jmp, stall_flg, bne, memread, memwrite;
    logic [31:0] PC;

    int checks = 0;
    int errors = 0;
    logic [15:0] rf_m [8];

    typedef struct packed {
        logic [15:0] r1;
        logic [15:0] r2;
        logic [7:0]  jt;
        logic [7:0]  id;
        logic [5:0]  ma;
        logic [4:0]  bo;
        logic [2:0]  fn;
        logic [2:0]  af;
        logic [1:0]  op;
        logic [1:0]  sh;
        logic [2:0]  dst;
        logic        jr;
        logic        rw;
        logic        jmp;
        logic        stall;
        logic        bne;
        logic        mr;
        logic        mw;
        logic [31:0] pc;
    } exp_t;

    fetch_decode dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .reg1data(reg1data), .reg2data(reg2data), .jtarget(jtarget), .idata(idata),
        .memaddr(memaddr), .boffset(boffset), .funct(funct), .ALUfunct(ALUfunct),
        .op(op), .shamt(shamt), .dst_reg(dst_reg), .jr(jr), .regwrite(regwrite),
        .jmp(jmp), .stall_flg(stall_flg), .bne(bne), .memread(memread),
        .memwrite(memwrite), .PC(PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t dut_bundle();
        exp_t g;
        g.r1 = reg1data; g.r2 = reg2data; g.jt = jtarget; g.id = idata;
        g.ma = memaddr;  g.bo = boffset;  g.fn = funct;   g.af = ALUfunct;
        g.op = op;       g.sh = shamt;    g.dst = dst_reg; g.jr = jr;
        g.rw = regwrite; g.jmp = jmp;     g.stall = stall_flg; g.bne = bne;
        g.mr = memread;  g.mw = memwrite; g.pc = PC;
        return g;
    endfunction

    function automatic exp_t bubble(input exp_t p);
        exp_t b;
        b = p;
        b.jr = 1'b0; b.rw = 1'b0; b.jmp = 1'b0; b.bne = 1'b0;
        b.mr = 1'b0; b.mw = 1'b0; b.stall = 1'b1;
        return b;
    endfunction

    // Architectural register read as seen during the decode cycle (includes writeback forwarding).
    function automatic logic [15:0] model_read(input logic [2:0] a);
        if (a == 3'd0) return 16'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return rf_m[a];
    endfunction

    // Expected Stage 1 bundle for one instruction, straight from the format table.
    function automatic exp_t ref_bundle(input logic [15:0] ins, input logic [31:0] pc, input exp_t prev);
        exp_t e;
        logic [2:0] s1, s2;
        e = '0; s1 = 3'd0; s2 = 3'd0;
        e.op = ins[15:14];
        e.pc = pc;
        if (e.op == 2'b00) begin
            s1 = ins[13:11]; s2 = ins[10:8];
            e.dst = ins[7:5]; e.sh = ins[4:3]; e.fn = ins[2:0]; e.af = ins[2:0]; e.rw = 1'b1;
        end else if (e.op == 2'b01) begin
            e.dst = ins[13:11]; e.fn = ins[10:8]; e.id = ins[7:0]; e.af = ins[10:8]; e.rw = 1'b1;
        end else if (e.op == 2'b10) begin
            e.fn = ins[10:8]; e.ma = ins[5:0];
            if (ins[10:8] == 3'd0) begin e.mr = 1'b1; e.rw = 1'b1; e.dst = ins[13:11]; end
            if (ins[10:8] == 3'd1) begin e.mw = 1'b1; s2 = ins[13:11]; end
        end else begin
            e.fn = ins[13:11];
            if (ins[13:11] == 3'd0) begin
                e.jt = ins[7:0]; e.jmp = 1'b1;
            end else if (ins[13:11] == 3'd1) begin
                s1 = ins[10:8]; e.jr = 1'b1;
            end else if (ins[13:11] == 3'd2) begin
                s1 = ins[10:8]; s2 = ins[7:5]; e.bo = ins[4:0]; e.af = 3'd1; e.bne = 1'b1;
            end else begin
                return bubble(prev);
            end
        end
        e.r1 = model_read(s1);
        e.r2 = model_read(s2);
        return e;
    endfunction

    task automatic tick();
        logic       we;
        logic [2:0] wa;
        logic [15:0] wd;
        we = wb_en; wa = wb_addr; wd = wb_data;
        @(posedge clk);
        #1;
        if (we && wa != 3'd0) rf_m[wa] = wd;
    endtask

    task automatic fetch_one(input logic [15:0] ins);
        imem_ack = 1'b1;
        imem_rdata = ins;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect_vld = 1'b0; redirect_pc = '0;
        ex_memread = 1'b0; ex_rd = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rf_m[i] = 16'h0;
    endtask

    task automatic test_reset();
        exp_t z;
        z = '0;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect_vld = 1'b0; redirect_pc = '0;
        ex_memread = 1'b0; ex_rd = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        checks++;
        if (dut_bundle() !== bubble(z)) begin
            errors++; $display("FAIL reset_bundle got=%h exp=%h", dut_bundle(), bubble(z));
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_fetch req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rf_m[i] = 16'h0;
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(k)) begin
                errors++; $display("FAIL stream_addr k=%0d req=%b addr=%h", k, imem_req, imem_addr);
            end
            fetch_one(16'h0000);
            checks++;
            if (stall_flg !== 1'b1) begin
                errors++; $display("FAIL stream_bubble k=%0d stall_flg=%b exp=1", k, stall_flg);
            end
            tick();
            checks++;
            if (stall_flg !== 1'b0 || PC !== 32'(k)) begin
                errors++; $display("FAIL stream_issue k=%0d stall_flg=%b PC=%h exp 0/%0d", k, stall_flg, PC, k);
            end
        end
    endtask

    task automatic test_bypass();
        do_reset();
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h1234; tick(); wb_en = 1'b0;
        fetch_one(16'h1220); tick();
        checks++;
        if (reg1data !== 16'h1234 || reg2data !== 16'h1234) begin
            errors++; $display("FAIL rf_read got=%h/%h exp=1234/1234", reg1data, reg2data);
        end
        fetch_one(16'h1220);
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'hBEEF; tick(); wb_en = 1'b0;
        checks++;
        if (reg1data !== 16'hBEEF || reg2data !== 16'hBEEF) begin
            errors++; $display("FAIL bypass got=%h/%h exp=beef/beef", reg1data, reg2data);
        end
        fetch_one(16'h0000);
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF; tick(); wb_en = 1'b0;
        checks++;
        if (reg1data !== 16'h0 || reg2data !== 16'h0) begin
            errors++; $display("FAIL r0_zero got=%h/%h exp=0/0", reg1data, reg2data);
        end
        fetch_one(16'h1220); tick();
        checks++;
        if (reg1data !== 16'hBEEF || reg2data !== 16'hBEEF) begin
            errors++; $display("FAIL rf_persist got=%h/%h exp=beef/beef", reg1data, reg2data);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        fetch_one(16'h9800); tick();
        checks++;
        if (memread !== 1'b1 || regwrite !== 1'b1 || dst_reg !== 3'd3 || stall_flg !== 1'b0) begin
            errors++; $display("FAIL load_decode mr=%b rw=%b dst=%0d stall=%b exp 1/1/3/0", memread, regwrite, dst_reg, stall_flg);
        end
        fetch_one(16'h1980);
        ex_memread = 1'b1; ex_rd = 3'd3; tick();
        checks++;
        if (stall_flg !== 1'b1 || regwrite !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL hazard_bubble stall=%b rw=%b req=%b exp 1/0/0", stall_flg, regwrite, imem_req);
        end
        ex_memread = 1'b0; tick();
        checks++;
        if (stall_flg !== 1'b1 || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_cycle stall=%b req=%b exp 1/0", stall_flg, imem_req);
        end
        tick();
        checks++;
        if (stall_flg !== 1'b0 || regwrite !== 1'b1 || dst_reg !== 3'd4 || PC !== 32'd1) begin
            errors++; $display("FAIL hazard_issue stall=%b rw=%b dst=%0d PC=%h exp 0/1/4/1", stall_flg, regwrite, dst_reg, PC);
        end
        fetch_one(16'h1980); ex_memread = 1'b1; ex_rd = 3'd5; tick(); ex_memread = 1'b0;
        checks++;
        if (stall_flg !== 1'b0 || PC !== 32'd2) begin
            errors++; $display("FAIL no_hazard stall=%b PC=%h exp 0/2", stall_flg, PC);
        end
        fetch_one(16'h0000); ex_memread = 1'b1; ex_rd = 3'd0; tick(); ex_memread = 1'b0;
        checks++;
        if (stall_flg !== 1'b0 || PC !== 32'd3) begin
            errors++; $display("FAIL r0_no_hazard stall=%b PC=%h exp 0/3", stall_flg, PC);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 16'h2220; redirect_vld = 1'b1; redirect_pc = 32'h40;
        tick();
        imem_ack = 1'b0; redirect_vld = 1'b0;
        checks++;
        if (stall_flg !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h40) begin
            errors++; $display("FAIL redir_drop stall=%b req=%b addr=%h exp 1/0/40", stall_flg, imem_req, imem_addr);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || stall_flg !== 1'b1) begin
            errors++; $display("FAIL redir_refetch req=%b addr=%h stall=%b exp 1/40/1", imem_req, imem_addr, stall_flg);
        end
        fetch_one(16'h0000); tick();
        checks++;
        if (stall_flg !== 1'b0 || PC !== 32'h40) begin
            errors++; $display("FAIL redir_issue stall=%b PC=%h exp 0/40", stall_flg, PC);
        end
        fetch_one(16'h2220); redirect_vld = 1'b1; redirect_pc = 32'h80; tick(); redirect_vld = 1'b0;
        checks++;
        if (stall_flg !== 1'b1 || regwrite !== 1'b0) begin
            errors++; $display("FAIL redir_in_issue stall=%b rw=%b exp 1/0", stall_flg, regwrite);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            errors++; $display("FAIL redir_issue_addr req=%b addr=%h exp 1/80", imem_req, imem_addr);
        end
        redirect_vld = 1'b1; redirect_pc = 32'hFFFF_FFFF; tick(); redirect_vld = 1'b0; tick();
        fetch_one(16'h0000);
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL pc_wrap addr=%h exp=0", imem_addr);
        end
        tick();
        checks++;
        if (PC !== 32'hFFFF_FFFF || stall_flg !== 1'b0) begin
            errors++; $display("FAIL wrap_issue PC=%h stall=%b exp ffffffff/0", PC, stall_flg);
        end
    endtask

    task automatic test_bne();
        do_reset();
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h0222; tick();
        wb_addr = 3'd7; wb_data = 16'h7777; tick(); wb_en = 1'b0;
        fetch_one(16'hD2E5); tick();
        checks++;
        if (bne !== 1'b1 || ALUfunct !== 3'b001 || boffset !== 5'd5 || regwrite !== 1'b0 ||
            reg1data !== 16'h0222 || reg2data !== 16'h7777 || stall_flg !== 1'b0) begin
            errors++; $display("FAIL bne bne=%b alu=%0d boff=%0d rw=%b r1=%h r2=%h stall=%b exp 1/1/5/0/0222/7777/0",
                               bne, ALUfunct, boffset, regwrite, reg1data, reg2data, stall_flg);
        end
    endtask

    task automatic test_jmp();
        do_reset();
        fetch_one(16'h0000); tick();
        fetch_one(16'hC07F); tick();
`ifdef NQ_JMP_EARLY_EN
        checks++;
        if (jmp !== 1'b0 || stall_flg !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h7F) begin
            errors++; $display("FAIL jmp_early jmp=%b stall=%b req=%b addr=%h exp 0/1/1/7f", jmp, stall_flg, imem_req, imem_addr);
        end
        fetch_one(16'hC07F); redirect_vld = 1'b1; redirect_pc = 32'h33; tick(); redirect_vld = 1'b0;
        checks++;
        if (imem_addr !== 32'h33) begin
            errors++; $display("FAIL jmp_vs_redirect addr=%h exp=33", imem_addr);
        end
`else
        checks++;
        if (jmp !== 1'b1 || jtarget !== 8'h7F || stall_flg !== 1'b0 || PC !== 32'd1 || imem_addr !== 32'd2) begin
            errors++; $display("FAIL jmp_late jmp=%b jt=%h stall=%b PC=%h addr=%h exp 1/7f/0/1/2", jmp, jtarget, stall_flg, PC, imem_addr);
        end
`endif
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        // jmp handling depends on the build option and is covered by test_jmp.
        if (w[15:14] == 2'b11 && w[13:11] == 3'd0) w[13:11] = 3'd1;
        return w;
    endfunction

    task automatic rand_wb();
        wb_en   = 1'($urandom_range(0, 1));
        wb_addr = 3'($urandom_range(0, 7));
        wb_data = 16'($urandom);
    endtask

    task automatic test_random();
        exp_t prev, e;
        logic [15:0] ins;
        logic [31:0] pc;
        do_reset();
        prev = '0; prev.stall = 1'b1; pc = 32'h0;
        for (int k = 0; k < 60; k++) begin
            ins = rand_instr();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== pc) begin
                errors++; $display("FAIL rnd_fetch k=%0d req=%b addr=%h exp 1/%h", k, imem_req, imem_addr, pc);
            end
            rand_wb();
            fetch_one(ins);
            checks++;
            if (dut_bundle() !== bubble(prev) || imem_req !== 1'b0) begin
                errors++; $display("FAIL rnd_bubble k=%0d got=%h exp=%h req=%b", k, dut_bundle(), bubble(prev), imem_req);
            end
            rand_wb();
            e = ref_bundle(ins, pc, prev);
            tick();
            checks++;
            if (dut_bundle() !== e) begin
                errors++; $display("FAIL rnd_issue k=%0d ins=%h got=%h exp=%h", k, ins, dut_bundle(), e);
            end
            prev = e;
            pc = pc + 32'd1;
        end
        wb_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_bypass();
        test_load_use();
        test_redirect();
        test_bne();
        test_jmp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
